// File: rtl/avalon_io_responder_pkg.sv
// Shared types for the Avalon IO responder: controller states, lane index and open-bus default.

package avalon_io_responder_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StXfer = 1'b1
   } state_e;

   typedef logic [1:0] lane_t;

   localparam logic [7:0] OPEN_BUS_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/avalon_io_responder_if.sv
// Avalon IO slave bus plus the byte-wide peripheral port bus seen by the responder.

interface avalon_io_responder_if;

   logic [15:0] avalon_io_address;
   logic [3:0]  avalon_io_byteenable;
   logic        avalon_io_read;
   logic        avalon_io_write;
   logic [31:0] avalon_io_writedata;
   logic        avalon_io_waitrequest;
   logic [31:0] avalon_io_readdata;
   logic        avalon_io_readdatavalid;

   logic [15:0] port_address;
   logic        port_read;
   logic        port_write;
   logic [7:0]  port_writedata;
   logic [7:0]  port_readdata;
   logic        port_ack;
   logic        io_timeout;

   modport slave (
      input  avalon_io_address, avalon_io_byteenable, avalon_io_read, avalon_io_write,
      input  avalon_io_writedata, port_readdata, port_ack,
      output avalon_io_waitrequest, avalon_io_readdata, avalon_io_readdatavalid,
      output port_address, port_read, port_write, port_writedata, io_timeout
   );

   modport master (
      output avalon_io_address, avalon_io_byteenable, avalon_io_read, avalon_io_write,
      output avalon_io_writedata, port_readdata, port_ack,
      input  avalon_io_waitrequest, avalon_io_readdata, avalon_io_readdatavalid,
      input  port_address, port_read, port_write, port_writedata, io_timeout
   );

endinterface

// File: rtl/io_lane_pick.sv
// Lowest-set-bit priority encoder: selects the next byte lane still pending in the mask.

module io_lane_pick
   import avalon_io_responder_pkg::*;
(
   input  logic [3:0] i_mask,
   output lane_t      o_lane,
   output logic       o_any
);

   always_comb begin
      o_lane = 2'd0;
      if (i_mask[0]) begin
         o_lane = 2'd0;
      end else if (i_mask[1]) begin
         o_lane = 2'd1;
      end else if (i_mask[2]) begin
         o_lane = 2'd2;
      end else if (i_mask[3]) begin
         o_lane = 2'd3;
      end
   end

   assign o_any = |i_mask;

endmodule

// File: rtl/avalon_io_responder.sv
// Avalon-MM IO responder: splits 32-bit accesses into ascending byte accesses on the port bus,
// with per-byte ack timeout and open-bus fill for missing or disabled read lanes.

module avalon_io_responder
   import avalon_io_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32,
   parameter logic [7:0]  OPEN_BUS_BYTE  = OPEN_BUS_BYTE_DEFAULT
) (
   input logic                  clk,
   input logic                  rst,
   avalon_io_responder_if.slave bus
);

   localparam int unsigned      CNT_W         = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]      OPEN_BUS_WORD = {4{OPEN_BUS_BYTE}};

   state_e           r_state, w_state_next;
   logic [3:0]       r_mask, w_mask_next;
   logic [13:0]      r_addr, w_addr_next;
   logic [31:0]      r_wdata, w_wdata_next;
   logic [31:0]      r_rbuf, w_rbuf_next;
   logic             r_is_read, w_is_read_next;
   logic             r_port_read, w_port_read_next;
   logic             r_port_write, w_port_write_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_rdvalid, w_rdvalid_next;
   logic             r_timeout, w_timeout_next;

   lane_t            w_lane;
   logic             w_any;
   logic             w_strobe;
   logic             w_byte_done;
   logic [3:0]       w_mask_left;
   logic             w_unused_addr;

   io_lane_pick u_lane_pick (
      .i_mask (r_mask),
      .o_lane (w_lane),
      .o_any  (w_any)
   );

   assign w_strobe      = r_port_read | r_port_write;
   assign w_mask_left   = r_mask & ~(4'b0001 << w_lane);
   assign w_unused_addr = ^bus.avalon_io_address[1:0];

   always_comb begin
      w_state_next      = r_state;
      w_mask_next       = r_mask;
      w_addr_next       = r_addr;
      w_wdata_next      = r_wdata;
      w_rbuf_next       = r_rbuf;
      w_is_read_next    = r_is_read;
      w_port_read_next  = r_port_read;
      w_port_write_next = r_port_write;
      w_cnt_next        = r_cnt;
      w_rdvalid_next    = 1'b0;
      w_timeout_next    = 1'b0;
      w_byte_done       = 1'b0;

      case (r_state)
         StIdle: begin
            // Write has priority when both requests are raised together.
            if (bus.avalon_io_write || bus.avalon_io_read) begin
               w_addr_next    = bus.avalon_io_address[15:2];
               w_mask_next    = bus.avalon_io_byteenable;
               w_wdata_next   = bus.avalon_io_writedata;
               w_rbuf_next    = OPEN_BUS_WORD;
               w_is_read_next = ~bus.avalon_io_write;
               w_cnt_next     = '0;
               if (|bus.avalon_io_byteenable) begin
                  w_state_next      = StXfer;
                  w_port_write_next = bus.avalon_io_write;
                  w_port_read_next  = ~bus.avalon_io_write;
               end else begin
                  w_rdvalid_next = ~bus.avalon_io_write;
               end
            end
         end

         StXfer: begin
            if (w_strobe) begin
               if (bus.port_ack) begin
                  w_byte_done = 1'b1;
                  if (r_is_read) begin
                     w_rbuf_next[{w_lane, 3'b000} +: 8] = bus.port_readdata;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  w_byte_done    = 1'b1;
                  w_timeout_next = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end

               if (w_byte_done) begin
                  w_mask_next       = w_mask_left;
                  w_cnt_next        = '0;
                  w_port_read_next  = 1'b0;
                  w_port_write_next = 1'b0;
                  if (w_mask_left == 4'b0000) begin
                     w_state_next   = StIdle;
                     w_rdvalid_next = r_is_read;
                  end
               end
            end else if (w_any) begin
               // Gap cycle over: raise the strobe for the next pending lane.
               w_port_read_next  = r_is_read;
               w_port_write_next = ~r_is_read;
            end else begin
               w_state_next = StIdle;
            end
         end

         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_mask       <= 4'b0000;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rbuf       <= 32'hFFFF_FFFF;
         r_is_read    <= 1'b0;
         r_port_read  <= 1'b0;
         r_port_write <= 1'b0;
         r_cnt        <= '0;
         r_rdvalid    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_mask       <= w_mask_next;
         r_addr       <= w_addr_next;
         r_wdata      <= w_wdata_next;
         r_rbuf       <= w_rbuf_next;
         r_is_read    <= w_is_read_next;
         r_port_read  <= w_port_read_next;
         r_port_write <= w_port_write_next;
         r_cnt        <= w_cnt_next;
         r_rdvalid    <= w_rdvalid_next;
         r_timeout    <= w_timeout_next;
      end
   end

   assign bus.avalon_io_waitrequest   = (r_state != StIdle);
   assign bus.avalon_io_readdata      = r_rbuf;
   assign bus.avalon_io_readdatavalid = r_rdvalid;
   assign bus.port_address            = {r_addr, w_lane};
   assign bus.port_read               = r_port_read;
   assign bus.port_write              = r_port_write;
   assign bus.port_writedata          = r_wdata[{w_lane, 3'b000} +: 8];
   assign bus.io_timeout              = r_timeout;

endmodule

// File: tb/tb_avalon_io_responder.sv
// Scoreboard bench for avalon_io_responder: byte-level reference model, peripheral model,
// directed corner cases and randomized traffic.

module tb_avalon_io_responder;

   localparam int TMO = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   avalon_io_responder_if bus ();

   avalon_io_responder #(
      .TIMEOUT_CYCLES (TMO),
      .OPEN_BUS_BYTE  (8'hFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
   } acc_t;

   acc_t        exp_acc[$];
   logic [31:0] exp_rd[$];
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned cyc = 0;
   int unsigned exp_tmo = 0;
   int unsigned tmo_seen = 0;
   int unsigned rdv_cyc = 0;
   int unsigned rdv_count = 0;
   logic [31:0] last_rdata = 32'h0;
   int          ack_mode = 0;
   bit          stray_en = 1'b0;

   logic [7:0] ref_mem [0:65535];
   logic [7:0] per_mem [0:65535];

   always @(posedge clk) cyc <= cyc + 1;

   // Ports 0x03xx with byte offset 2 are unpopulated and never ack.
   function automatic bit present(input logic [15:0] a);
      return !((a[15:8] == 8'h03) && (a[1:0] == 2'd2));
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic model_push(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] res;
      logic [15:0] ba;
      res = 32'hFFFF_FFFF;
      if (!rd && !wr) return;
      for (int l = 0; l < 4; l++) begin
         ba = {addr[15:2], 2'(l)};
         if (be[l]) begin
            exp_acc.push_back('{w: wr, a: ba, d: wr ? wd[8*l +: 8] : 8'h00});
            if (!present(ba)) exp_tmo++;
            else if (wr) ref_mem[ba] = wd[8*l +: 8];
            else res[8*l +: 8] = ref_mem[ba];
         end
      end
      if (!wr) exp_rd.push_back(res);
   endtask

   task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, output int unsigned t);
      int unsigned guard;
      guard = 0;
      @(negedge clk);
      while (bus.avalon_io_waitrequest && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) check("accept_wait", 64'd1, 64'd0);
      model_push(rd, wr, addr, be, wd);
      t = cyc;
      bus.avalon_io_address    = addr;
      bus.avalon_io_byteenable = be;
      bus.avalon_io_writedata  = wd;
      bus.avalon_io_read       = rd;
      bus.avalon_io_write      = wr;
      @(posedge clk);
      #1;
      bus.avalon_io_read  = 1'b0;
      bus.avalon_io_write = 1'b0;
   endtask

   task automatic wait_done();
      int unsigned guard;
      guard = 0;
      @(negedge clk);
      while ((bus.avalon_io_waitrequest || exp_rd.size() != 0 || exp_acc.size() != 0)
             && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) check("done_wait", 64'd1, 64'd0);
   endtask

   // Peripheral: acks after ack_mode strobe cycles (random 0..3 when negative).
   initial begin : periph
      int pc;
      int dly;
      pc = 0;
      dly = 0;
      bus.port_ack = 1'b0;
      bus.port_readdata = 8'h00;
      forever begin
         @(negedge clk);
         bus.port_ack = 1'b0;
         bus.port_readdata = 8'($urandom);
         if (rst) begin
            pc = 0;
         end else if (bus.port_read || bus.port_write) begin
            if (pc == 0) dly = (ack_mode < 0) ? int'($urandom_range(3, 0)) : ack_mode;
            if (pc == dly && present(bus.port_address)) begin
               bus.port_ack = 1'b1;
               if (bus.port_write) per_mem[bus.port_address] = bus.port_writedata;
               else bus.port_readdata = per_mem[bus.port_address];
            end
            pc++;
         end else begin
            pc = 0;
            if (stray_en && $urandom_range(3, 0) == 0) bus.port_ack = 1'b1;
         end
      end
   end

   initial begin : monitor
      logic prev;
      logic strobe;
      acc_t act;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.io_timeout) tmo_seen++;
         if (bus.avalon_io_readdatavalid) begin
            rdv_cyc = cyc;
            rdv_count++;
            last_rdata = bus.avalon_io_readdata;
            if (exp_rd.size() == 0) check("rdv_unexpected", 64'd1, 64'd0);
            else check("readdata", 64'(bus.avalon_io_readdata), 64'(exp_rd.pop_front()));
         end
         strobe = bus.port_read | bus.port_write;
         if (bus.port_read && bus.port_write) check("strobe_exclusive", 64'd1, 64'd0);
         if (strobe && !prev) begin
            act = '{w: bus.port_write, a: bus.port_address,
                    d: bus.port_write ? bus.port_writedata : 8'h00};
            if (exp_acc.size() == 0) check("strobe_unexpected", 64'd1, 64'd0);
            else check("port_access", 64'(act), 64'(exp_acc.pop_front()));
         end
         prev = strobe;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

   initial begin : stim
      int unsigned t;
      int unsigned base;
      int unsigned n;
      logic [7:0] v;
      for (int i = 0; i < 65536; i++) begin
         v = 8'(i * 7 + 3);
         ref_mem[i] = v;
         per_mem[i] = v;
      end
      ref_mem[16'h0020] = 8'h5A; per_mem[16'h0020] = 8'h5A;
      ref_mem[16'h0389] = 8'hAB; per_mem[16'h0389] = 8'hAB;
      ref_mem[16'h0100] = 8'h00; per_mem[16'h0100] = 8'h00;

      rst = 1'b1;
      bus.avalon_io_address = 16'h0;
      bus.avalon_io_byteenable = 4'h0;
      bus.avalon_io_read = 1'b0;
      bus.avalon_io_write = 1'b0;
      bus.avalon_io_writedata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_waitrequest", 64'(bus.avalon_io_waitrequest), 64'd0);
      check("rst_rdvalid", 64'(bus.avalon_io_readdatavalid), 64'd0);
      check("rst_readdata", 64'(bus.avalon_io_readdata), 64'hFFFF_FFFF);
      check("rst_port_read", 64'(bus.port_read), 64'd0);
      check("rst_port_write", 64'(bus.port_write), 64'd0);
      check("rst_port_address", 64'(bus.port_address), 64'd0);
      check("rst_port_writedata", 64'(bus.port_writedata), 64'd0);
      check("rst_io_timeout", 64'(bus.io_timeout), 64'd0);
      rst = 1'b0;

      // Single lane, immediate ack.
      issue(1'b1, 1'b0, 16'h0020, 4'b0001, 32'h0, t);
      wait_done();
      check("lat_1lane", 64'(rdv_cyc - t), 64'd2);
      check("rd_0020", 64'(last_rdata), 64'hFFFF_FF5A);

      // Four lanes, immediate ack.
      issue(1'b1, 1'b0, 16'h0010, 4'b1111, 32'h0, t);
      wait_done();
      check("lat_4lane", 64'(rdv_cyc - t), 64'd8);

      // Four-lane posted write, ack after 2 cycles; waitrequest stays high until done.
      ack_mode = 2;
      issue(1'b0, 1'b1, 16'h0400, 4'b1111, 32'h4433_2211, t);
      n = 0;
      @(negedge clk);
      while (bus.avalon_io_waitrequest && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("wr_waitreq_cycles", 64'(n), 64'(4 * (2 + 1) + 3));
      ack_mode = 0;
      issue(1'b1, 1'b0, 16'h0400, 4'b1111, 32'h0, t);
      wait_done();
      check("rd_0400", 64'(last_rdata), 64'h4433_2211);

      // Absent lane times out.
      base = tmo_seen;
      issue(1'b1, 1'b0, 16'h0388, 4'b0110, 32'h0, t);
      wait_done();
      check("tmo_pulses", 64'(tmo_seen - base), 64'd1);
      check("rd_0388", 64'(last_rdata), 64'hFFFF_ABFF);

      // Empty byteenable read and write.
      issue(1'b1, 1'b0, 16'h0050, 4'b0000, 32'h0, t);
      @(negedge clk);
      check("be0_rd_waitreq", 64'(bus.avalon_io_waitrequest), 64'd0);
      wait_done();
      check("be0_rd_lat", 64'(rdv_cyc - t), 64'd1);
      check("be0_rd_data", 64'(last_rdata), 64'hFFFF_FFFF);
      issue(1'b0, 1'b1, 16'h0054, 4'b0000, 32'hDEAD_BEEF, t);
      @(negedge clk);
      check("be0_wr_waitreq", 64'(bus.avalon_io_waitrequest), 64'd0);

      // Ack lands in the final timeout cycle: ack wins.
      ack_mode = TMO - 1;
      base = tmo_seen;
      issue(1'b1, 1'b0, 16'h0100, 4'b0001, 32'h0, t);
      wait_done();
      check("ack_at_limit_data", 64'(last_rdata), 64'hFFFF_FF00);
      check("ack_at_limit_tmo", 64'(tmo_seen - base), 64'd0);
      check("ack_at_limit_lat", 64'(rdv_cyc - t), 64'(TMO + 1));
      ack_mode = 0;

      // Read and write together: only the write happens.
      base = rdv_count;
      issue(1'b1, 1'b1, 16'h0200, 4'b0001, 32'h0000_00C3, t);
      wait_done();
      repeat (3) @(negedge clk);
      check("rw_no_rdv", 64'(rdv_count - base), 64'd0);
      issue(1'b1, 1'b0, 16'h0200, 4'b0001, 32'h0, t);
      wait_done();
      check("rw_readback", 64'(last_rdata), 64'hFFFF_FFC3);

      // Reset in the middle of a four-lane read.
      ack_mode = 3;
      issue(1'b1, 1'b0, 16'h0040, 4'b1111, 32'h0, t);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      exp_acc.delete();
      exp_rd.delete();
      base = rdv_count;
      n = tmo_seen;
      @(negedge clk);
      check("midrst_port_read", 64'(bus.port_read), 64'd0);
      check("midrst_port_write", 64'(bus.port_write), 64'd0);
      check("midrst_waitreq", 64'(bus.avalon_io_waitrequest), 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_no_rdv", 64'(rdv_count - base), 64'd0);
      check("midrst_no_tmo", 64'(tmo_seen - n), 64'd0);
      ack_mode = 0;
      issue(1'b1, 1'b0, 16'h0044, 4'b0011, 32'h0, t);
      wait_done();
      check("post_rst_rdv", 64'(rdv_count - base), 64'd1);

      // Randomized traffic with random ack delays and stray acks between strobes.
      ack_mode = -1;
      stray_en = 1'b1;
      for (int k = 0; k < 120; k++) begin
         int unsigned op;
         op = $urandom_range(9, 0);
         issue(op < 5, op >= 5, 16'($urandom_range(16'h03FF, 0)), 4'($urandom),
               $urandom, t);
      end
      wait_done();
      stray_en = 1'b0;
      repeat (3) @(negedge clk);
      check("tmo_total", 64'(tmo_seen), 64'(exp_tmo));
      check("queues_empty", 64'(exp_acc.size() + exp_rd.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/avalon_io_responder.md
Name: avalon_io_responder

Overview:
- Avalon-MM IO slave: the responder end of the CPU's Avalon IO master interface (16-bit address, 4-bit byteenable, waitrequest, readdatavalid).
- Splits each 32-bit access into sequential byte-wide accesses on an 8-bit peripheral port bus with an ack handshake.
- Returns assembled read data; an absent port returns open-bus bytes after a timeout.
- Sits between the ao486 IO master and the Towns byte-wide IO peripherals.

Parameters:
- TIMEOUT_CYCLES, 32: cycles the port strobe is held per byte without ack before the byte is abandoned (>=2).
- OPEN_BUS_BYTE, 8'hFF: data returned for timed-out, disabled or empty-byteenable read lanes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- avalon_io_address  in  16  word address, bits [1:0] ignored
- avalon_io_byteenable  in  4  lane enables
- avalon_io_read  in  1  read request
- avalon_io_write  in  1  write request
- avalon_io_writedata  in  32  write data, lane-aligned
- avalon_io_waitrequest  out  1  high = command not accepted
- avalon_io_readdata  out  32  read result
- avalon_io_readdatavalid  out  1  one-cycle read result strobe
- port_address  out  16  byte address {word[15:2], lane}
- port_read  out  1  byte read strobe, level, held until ack/timeout
- port_write  out  1  byte write strobe, level, held until ack/timeout
- port_writedata  out  8  write byte
- port_readdata  in  8  read byte, valid with port_ack
- port_ack  in  1  byte access complete
- io_timeout  out  1  one-cycle pulse per timed-out byte

Behaviour:
- Reset values:
  - State IDLE; waitrequest 0; readdatavalid 0; readdata 32'hFFFFFFFF.
  - port_read/port_write 0; port_address 0; port_writedata 0; io_timeout 0.
  - Lane mask 0; timeout counter 0.
- States: IDLE, XFER.
- waitrequest = (state != IDLE). Combinational from the state register only, never from the request inputs.
- IDLE, write=1:
  - Latch address[15:2], byteenable as lane mask, writedata; readdata buffer set to {4{OPEN_BUS_BYTE}}.
  - Mask nonzero: next cycle XFER, port_write=1 for the lowest set lane. Mask zero: stay IDLE, access dropped.
  - Writes are posted: acceptance is the IDLE cycle itself.
- IDLE, read=1:
  - Same latch. Mask nonzero: XFER with port_read. Mask zero: next cycle readdatavalid=1, readdata={4{OPEN_BUS_BYTE}}.
- IDLE, read and write both high: write wins; read is dropped with no readdatavalid.
- XFER:
  - port_address={addr[15:2], lane}; port_writedata=writedata[8*lane+:8].
  - Counter increments each cycle the strobe is high.
  - port_ack=1: read captures port_readdata into buffer[lane]. Clear the lane bit, reset the counter, drop the strobe for one cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: buffer[lane] stays OPEN_BUS_BYTE, io_timeout pulses, lane bit cleared.
  - Ack in the timeout cycle: ack wins and no io_timeout.
  - Lanes are processed ascending, one strobe-low gap cycle between lanes.
  - Last lane done: next cycle state IDLE. If read, readdatavalid=1 with readdata=buffer in that same cycle, so a new command is acceptable on that cycle.
- Latency: single-byte read with ack in its first strobe cycle T+1 (accept at T) gives readdatavalid at T+2. Four immediately-acked lanes give readdatavalid at T+8.
- port_ack outside an active strobe is ignored.
- Reset mid-XFER: strobes drop next cycle, no readdatavalid, no io_timeout, mask cleared.
- Disabled read lanes return OPEN_BUS_BYTE.

Decomposition:
- Shared package: state encoding (IDLE/XFER), OPEN_BUS_BYTE default, lane index typedef (2 bits).
- One sub-module: io_lane_pick, a combinational lowest-set-bit priority encoder. It maps the 4-bit mask to a 2-bit lane plus an any-set flag.

Test Plan:
- Read 0x0020 be=0001; port acks immediately with 8'h5A -> port_address 0x0020, readdatavalid at T+2, readdata 32'hFFFFFF5A.
- Write 0x0400 be=1111 data 32'h44332211; acks after 2 cycles -> port writes 11@0400, 22@0401, 33@0402, 44@0403 in order. waitrequest low only at accept and after the last ack.
- Read 0x0388 be=0110; lane1 acks 8'hAB, lane2 never acks -> io_timeout pulse after 32 strobe cycles; readdata 32'hFFFFABFF.
- Read be=0000 -> no port strobe, readdatavalid next cycle, readdata 32'hFFFFFFFF. Write be=0000 -> no port strobe, waitrequest stays 0.
- Ack in the same cycle the counter hits 31 with 8'h00 -> byte 8'h00 and no io_timeout. Read and write asserted together -> only the write is performed.
- rst asserted mid-way through a 4-lane read -> strobes low next cycle, waitrequest 0, no readdatavalid; the next read completes normally.
